vector_issue_sequencer: RTL

Sequences one vector instruction at a time through the lane datapath of the RV32V execute stage. Accepts a decoded vector op with its `vl`/`vstart`, emits one element group of `NUM_LANES` elements per cycle with a lane-active mask, and honours pipeline stall, execute-busy back-pressure, flush, and trap/exception-return resumption. It sits between vector decode and the lane datapath. It owns the element index state that decode and the lanes consume.

---
 rtl/vector_issue_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer: steps one vector instruction through the lane
// datapath one element group per cycle. It owns the element index, presents
// a lane-active mask, and parks the restart index while a trap is serviced.
module vector_issue_sequencer #(
  parameter int NUM_LANES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_vl,
  input  logic [31:0]          req_vstart,
  input  logic                 stall,
  input  logic                 busy_ex,
  input  logic                 clear,
  input  logic                 trap,
  input  logic                 ex_return,
  output logic                 issue_valid,
  output logic [31:0]          issue_offset,
  output logic [NUM_LANES-1:0] issue_mask,
  output logic                 issue_first,
  output logic                 issue_last,
  output logic                 done,
  output logic [31:0]          vstart_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] offset;
  logic [31:0] vl_q;
  logic [31:0] resume_q;
  logic        first_q;
  logic        done_q;
  logic        fire;
  logic [32:0] group_end;

  // Group end is computed one bit wider so offsets near 2^32 cannot wrap
  // and falsely look short of vl.
  assign group_end    = {1'b0, offset} + 33'(NUM_LANES);
  assign issue_last   = group_end >= {1'b0, vl_q};
  assign issue_valid  = (state == S_RUN) && !busy_ex;
  assign fire         = issue_valid && !stall;
  assign issue_offset = offset;
  assign issue_first  = first_q;
  assign req_ready    = (state == S_IDLE);
  assign done         = done_q;
  assign vstart_out   = resume_q;

  // Per-lane activity: lane i carries element offset+i, active below vl.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_mask
    assign issue_mask[i] = ({1'b0, offset} + 33'(i)) < {1'b0, vl_q};
  end

  // Sequencing state: clear beats trap beats ex_return beats normal progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      offset   <= '0;
      vl_q     <= '0;
      resume_q <= '0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state <= S_IDLE;
      end else if (trap && (state == S_RUN)) begin
        // Any fire this cycle is dropped; the trapped group is redone.
        state    <= S_HOLD;
        resume_q <= offset;
      end else if (ex_return && (state == S_HOLD)) begin
        state   <= S_RUN;
        offset  <= resume_q;
        first_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              vl_q    <= req_vl;
              offset  <= req_vstart;
              first_q <= 1'b1;
              // Nothing to issue when the start index is already past vl.
              if (req_vstart >= req_vl) begin
                done_q <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (fire) begin
              offset  <= offset + 32'(NUM_LANES);
              first_q <= 1'b0;
              if (issue_last) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
